// File: rtl/ctrl_opcode_feeder.sv
// ctrl_opcode_feeder
// Issue stage in front of the combinational control decoder. Opcodes are
// buffered in a small FIFO and presented one at a time on a registered
// output; out_opcode[i] drives decoder input pi<i>. An optional bubble of
// BUBBLE idle cycles after every output handshake gives the downstream
// control-word register time to settle.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     upstream opcode valid
//   in_ready     FIFO can accept (~full, held 0 while rst is high)
//   in_opcode    opcode from upstream
//   flush        synchronous clear of buffered and presented opcodes
//   out_valid    out_opcode valid to the decoder stage
//   out_ready    downstream accepts
//   out_opcode   registered opcode, bit i -> decoder input pi<i>
//   level        FIFO occupancy, output register not included
//   empty        level == 0
//   full         level == DEPTH
//   issue_count  saturating count of output handshakes (CTRL_FEED_STATS_EN only)
//
// Build option: define CTRL_FEED_STATS_EN to add the issue_count port and
// counter. Without it the port and counter are absent.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing presented; pops the head as soon as the FIFO has data
// PRESENT | out_valid=1, out_opcode held until out_ready
// GAP     | bubble after a handshake; counts BUBBLE cycles down to 1
module ctrl_opcode_feeder #(
  parameter int DEPTH  = 4,
  parameter int OPW    = 7,
  parameter int BUBBLE = 0,
  parameter int CNTW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_opcode,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPW-1:0]           out_opcode,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
`ifdef CTRL_FEED_STATS_EN
  ,
  output logic [CNTW-1:0]          issue_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [3:0] BUB = 4'(BUBBLE);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (OPW != 7) ||
      (BUBBLE < 0) || (BUBBLE > 15) || (CNTW < 1)) begin : g_param_check
    $error("ctrl_opcode_feeder: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_q;
  logic [OPW-1:0]  mem [DEPTH];
  logic            push, pop;

  assign level     = level_q;
  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign in_ready  = ~full & ~rst;
  assign out_valid = (state == S_PRESENT);
  assign push      = in_valid & in_ready;

  // Pop decisions look only at the occupancy before this edge's push, so a
  // freshly written opcode is never read through in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (BUB != 4'd0) begin
            cnt_n   = BUB;
            state_n = S_GAP;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_GAP: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = S_PRESENT;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      out_opcode <= '0;
    end else if (flush) begin
      // out_opcode deliberately keeps its last value
      state   <= S_IDLE;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        out_opcode <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind a valid level.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_opcode;
  end

`ifdef CTRL_FEED_STATS_EN
  // A handshake discarded by flush is not counted; flush never clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count <= '0;
    end else if (!flush && out_valid && out_ready && (issue_count != '1)) begin
      issue_count <= issue_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_opcode_feeder.sv
// Testbench for ctrl_opcode_feeder. Two instances (BUBBLE=0 and BUBBLE=2)
// share one stimulus stream. Each lane keeps a timestamp model: an accepted
// opcode is presented at the first edge where the FIFO is non-empty, nothing
// is presented, and at least BUBBLE edges have passed since the last output
// handshake. A separate monitor pops a per-lane scoreboard on every output
// handshake to check ordering and content.
module tb_ctrl_opcode_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] in_opcode = '0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic void chk(int lane, string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %0h expected %0h at %0t", lane, nm, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int BUB = 2 * g;

    logic       iready, ovalid, empt, ful;
    logic [6:0] oop;
    logic [2:0] lvl;
`ifdef CTRL_FEED_STATS_EN
    logic [15:0] icnt;
`endif

    ctrl_opcode_feeder #(
      .DEPTH(4), .OPW(7), .BUBBLE(BUB), .CNTW(16)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (iready),
      .in_opcode  (in_opcode),
      .flush      (flush),
      .out_valid  (ovalid),
      .out_ready  (out_ready),
      .out_opcode (oop),
      .level      (lvl),
      .empty      (empt),
      .full       (ful)
`ifdef CTRL_FEED_STATS_EN
      ,
      .issue_count(icnt)
`endif
    );

    logic [6:0] mq[$];
    logic [6:0] expq[$];
    logic [6:0] mval;
    logic [6:0] e;
    bit         pres;
    bit         mpush;
    int         mlvl;
    int         last_hs;
    int         ecount;

    // reference model, checked #1 after each edge
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mq.delete();
        expq.delete();
        pres    = 1'b0;
        mval    = '0;
        last_hs = -100;
        ecount  = 0;
      end else begin
        ecount++;
        if (flush) begin
          mq.delete();
          expq.delete();
          pres    = 1'b0;
          last_hs = -100;
        end else begin
          mlvl  = mq.size();
          mpush = in_valid && (mlvl < 4);
          if (pres && out_ready) begin
            pres    = 1'b0;
            last_hs = ecount;
          end
          if (!pres && (mlvl > 0) && (last_hs + BUB <= ecount)) begin
            pres = 1'b1;
            mval = mq.pop_front();
          end
          if (mpush) begin
            mq.push_back(in_opcode);
            expq.push_back(in_opcode);
          end
        end
        #1;
        chk(g, "out_valid", int'(ovalid), int'(pres));
        chk(g, "out_opcode", int'(oop), int'(mval));
        chk(g, "level", int'(lvl), mq.size());
        chk(g, "empty", int'(empt), int'(mq.size() == 0));
        chk(g, "full", int'(ful), int'(mq.size() == 4));
        chk(g, "in_ready", int'(iready), int'(mq.size() < 4));
      end
    end

    // asynchronous reset must take effect before any clock edge
    always @(posedge rst) begin
      #1;
      chk(g, "rst_out_valid", int'(ovalid), 0);
      chk(g, "rst_out_opcode", int'(oop), 0);
      chk(g, "rst_level", int'(lvl), 0);
      chk(g, "rst_empty", int'(empt), 1);
      chk(g, "rst_in_ready", int'(iready), 0);
    end

    // scoreboard monitor: a handshake is visible mid-cycle before its edge
    initial begin
      forever begin
        @(negedge clk);
        #2;
        if (rst === 1'b0 && flush === 1'b0 && ovalid === 1'b1 && out_ready === 1'b1) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d sb_underflow: got %0h with no expected opcode at %0t", g, oop, $time);
          end else begin
            e = expq.pop_front();
            chk(g, "sb_order", int'(oop), int'(e));
          end
        end
      end
    end
  end

  task automatic drive(bit v, logic [6:0] op, bit rdy, bit fl);
    @(negedge clk);
    in_valid  = v;
    in_opcode = op;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 7'h00, rdy, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single opcode, latency and return to idle
    drive(1'b1, 7'h2A, 1'b1, 1'b0);
    idle(6, 1'b1);

    // fill while stalled, then drain back-to-back
    for (int i = 1; i <= 5; i++) drive(1'b1, 7'(i), 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(14, 1'b1);

    // three queued opcodes through the bubble lane
    for (int i = 0; i < 3; i++) drive(1'b1, 7'(8'h40 + i), 1'b0, 1'b0);
    idle(14, 1'b1);

    // flush a full FIFO with a concurrent push and handshake
    for (int i = 0; i < 6; i++) drive(1'b1, 7'(8'h10 + i), 1'b0, 1'b0);
    drive(1'b1, 7'h7F, 1'b1, 1'b1);
    idle(8, 1'b1);

    // asynchronous reset in the middle of a stall
    for (int i = 0; i < 4; i++) drive(1'b1, 7'(8'h50 + i), 1'b0, 1'b0);
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    #3 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3, 1'b1);

    // randomized traffic with varying pressure on both sides
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        drive($urandom_range(0, 99) < 30 + 15 * ph,
              7'($urandom),
              $urandom_range(0, 99) < 80 - 15 * ph,
              $urandom_range(0, 99) < 2);
      end
    end
    idle(30, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
